// File: rtl/rv_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package rv_ifu_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } ifu_entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction
endpackage

// File: rtl/rv_sync_fifo.sv
// Synchronous FIFO with clear and occupancy count; empty head reads as zero.
module rv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH):0]       count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;

  // DEPTH is a power of two, so pointer wrap falls out of the natural overflow.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = (count != '0) ? mem[rptr] : '0;

  assert property (@(posedge clk) disable iff (rst)
    !(push && !clr && count == CW'(DEPTH)));
endmodule

// File: rtl/rv_ifu.sv
// Instruction fetch unit: sequential PC, credit-based imem requests, decode FIFO.
// Optional RV_IFU_MISALIGN_EN: halt on misaligned redirect and flag misalign_o.
module rv_ifu
  import rv_ifu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [ILEN-1:0] id_instr_o,
  output logic [XLEN-1:0] id_pc_o
`ifdef RV_IFU_MISALIGN_EN
  ,
  output logic            misalign_o
`endif
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam int EW  = $bits(ifu_entry_t);
  localparam logic [CW:0] DEPTH_C = CW1'(DEPTH);

  logic [XLEN-1:0] fetch_pc, rsp_pc, target;
  logic            outstanding, halted, accept;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            push, pop;
  ifu_entry_t      wentry, head;
  logic [EW-1:0]   head_bits;

`ifdef RV_IFU_MISALIGN_EN
  logic tgt_misaligned;
  assign tgt_misaligned = |redirect_pc_i[1:0];
  assign target         = redirect_pc_i;

  always_ff @(posedge clk) begin
    if (rst)             halted <= 1'b0;
    else if (redirect_i) halted <= tgt_misaligned;
  end
  assign misalign_o = halted;
`else
  assign target = redirect_pc_i & ~XLEN'(3);
  assign halted = 1'b0;
`endif

  // Credit counts buffered plus in-flight entries; a same-cycle pop is ignored.
  assign credit_used = {1'b0, fifo_count} + CW1'(outstanding);
  assign imem_req_o  = !rst && !redirect_i && !halted && (credit_used < DEPTH_C);
  assign imem_addr_o = fetch_pc;
  assign accept      = imem_req_o && imem_gnt_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= '0;
      outstanding <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc    <= target;
      outstanding <= 1'b0;
    end else begin
      outstanding <= accept;
      if (accept) begin
        fetch_pc <= next_pc(fetch_pc);
        rsp_pc   <= fetch_pc;
      end
    end
  end

  assign push       = imem_rvalid_i && !redirect_i;
  assign wentry     = '{pc: rsp_pc, instr: imem_rdata_i};
  assign id_valid_o = (fifo_count != '0) && !redirect_i;
  assign pop        = id_valid_o && id_ready_i;

  rv_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (redirect_i),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head_bits),
    .count (fifo_count)
  );

  assign head       = head_bits;
  assign id_instr_o = head.instr;
  assign id_pc_o    = head.pc;
endmodule

// File: tb/tb_rv_ifu.sv
// Self-checking bench for rv_ifu: the delivered stream must be the contiguous
// PC sequence from the last reset/redirect target, each with its memory word.
module tb_rv_ifu;
  import rv_ifu_pkg::*;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_instr_o;
  logic [63:0] id_pc_o;
`ifdef RV_IFU_MISALIGN_EN
  logic        misalign_o;
`endif

  rv_ifu #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .id_instr_o(id_instr_o), .id_pc_o(id_pc_o)
`ifdef RV_IFU_MISALIGN_EN
    , .misalign_o(misalign_o)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_pc = '0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  // Instruction memory: accepted request seen mid-cycle, answered next cycle.
  logic        acc_n = 1'b0;
  logic [63:0] addr_n = '0;
  always @(negedge clk) begin
    acc_n  = imem_req_o && imem_gnt_i;
    addr_n = imem_addr_o;
  end
  always @(posedge clk) begin
    #1;
    imem_rvalid_i = acc_n;
    imem_rdata_i  = acc_n ? mem_word(addr_n) : $urandom();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; imem_gnt_i = 1'b1; id_ready_i = 1'b1;
    repeat (3) step();
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", imem_req_o); end
    checks++; if (imem_addr_o !== 64'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr_o); end
    checks++; if (id_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", id_valid_o); end
    checks++; if (id_instr_o !== 32'h0 || id_pc_o !== 64'h0) begin failures++; $display("FAIL reset_data instr=%h pc=%h exp=0", id_instr_o, id_pc_o); end
`ifdef RV_IFU_MISALIGN_EN
    checks++; if (misalign_o !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%0b exp=0", misalign_o); end
`endif
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h0) begin failures++; $display("FAIL c0_req req=%0b addr=%h exp=1/0", imem_req_o, imem_addr_o); end
    step();
    @(negedge clk);
    checks++; if (id_valid_o !== 1'b0 || imem_addr_o !== 64'h4) begin failures++; $display("FAIL c1 valid=%0b addr=%h exp=0/4", id_valid_o, imem_addr_o); end
    step();
    @(negedge clk);
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 64'h0 || id_instr_o !== mem_word(64'h0)) begin
      failures++; $display("FAIL c2_first valid=%0b pc=%h instr=%h exp=1/0/%h", id_valid_o, id_pc_o, id_instr_o, mem_word(64'h0));
    end
    exp_pc = 64'h4;
    step();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (id_valid_o !== 1'b1 || id_pc_o !== exp_pc || id_instr_o !== mem_word(exp_pc)) begin
        failures++; $display("FAIL stream valid=%0b pc=%h instr=%h exp=1/%h/%h", id_valid_o, id_pc_o, id_instr_o, exp_pc, mem_word(exp_pc));
      end
      exp_pc += 64'd4;
      step();
    end
  endtask

  task automatic test_backpressure();
    int n;
    id_ready_i = 1'b0;
    repeat (9) step();
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL bp_req_drop got=%0b exp=0", imem_req_o); end
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== exp_pc) begin failures++; $display("FAIL bp_head valid=%0b pc=%h exp=1/%h", id_valid_o, id_pc_o, exp_pc); end
    step();
    imem_gnt_i = 1'b0; id_ready_i = 1'b1; n = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      @(negedge clk);
      if (id_valid_o && id_ready_i) begin
        checks++;
        if (id_pc_o !== exp_pc || id_instr_o !== mem_word(exp_pc)) begin
          failures++; $display("FAIL bp_drain pc=%h instr=%h exp=%h/%h", id_pc_o, id_instr_o, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 64'd4; n++;
      end
      step();
    end
    checks++; if (n != DEPTH) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", n, DEPTH); end
    imem_gnt_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (id_valid_o && id_ready_i) begin
        checks++;
        if (id_pc_o !== exp_pc || id_instr_o !== mem_word(exp_pc)) begin
          failures++; $display("FAIL bp_resume pc=%h exp=%h", id_pc_o, exp_pc);
        end
        exp_pc += 64'd4;
      end
      step();
    end
  endtask

  task automatic test_gnt_stall();
    logic [63:0] a0;
    imem_gnt_i = 1'b0;
    a0 = '0;
    for (int i = 0; i < 3 + 8; i++) begin
      if (i == 3) imem_gnt_i = 1'b1;
      @(negedge clk);
      if (i == 0) a0 = imem_addr_o;
      else if (i < 3) begin
        checks++;
        if (imem_addr_o !== a0 || imem_req_o !== 1'b1) begin
          failures++; $display("FAIL stall_hold addr=%h req=%0b exp=%h/1", imem_addr_o, imem_req_o, a0);
        end
      end
      if (id_valid_o && id_ready_i) begin
        checks++;
        if (id_pc_o !== exp_pc || id_instr_o !== mem_word(exp_pc)) begin
          failures++; $display("FAIL stall_stream pc=%h exp=%h", id_pc_o, exp_pc);
        end
        exp_pc += 64'd4;
      end
      step();
    end
  endtask

  task automatic test_redirect();
    id_ready_i = 1'b0; imem_gnt_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 64'h1000;
    step();
    redirect_i = 1'b0;
    repeat (3) step();
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || id_pc_o !== 64'h1000) begin failures++; $display("FAIL rd_setup req=%0b pc=%h exp=1/1000", imem_req_o, id_pc_o); end
    step();
    redirect_i = 1'b1; redirect_pc_i = 64'h100; id_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (id_valid_o !== 1'b0) begin failures++; $display("FAIL rd_gap t+%0d valid=%0b exp=0", k, id_valid_o); end
      if (k == 1) begin
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h100) begin failures++; $display("FAIL rd_newreq req=%0b addr=%h exp=1/100", imem_req_o, imem_addr_o); end
      end
      step();
      redirect_i = 1'b0;
    end
    @(negedge clk);
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 64'h100 || id_instr_o !== mem_word(64'h100)) begin
      failures++; $display("FAIL rd_first valid=%0b pc=%h exp=1/100", id_valid_o, id_pc_o);
    end
    exp_pc = 64'h104;
    step();
  endtask

  task automatic test_redirect_ready();
    logic [63:0] tgt;
`ifdef RV_IFU_MISALIGN_EN
    tgt = 64'h0000_0001_2345_6700;
    redirect_pc_i = tgt;
`else
    tgt = 64'h0000_0001_2345_6700;
    redirect_pc_i = 64'h0000_0001_2345_6702;
`endif
    for (int i = 0; i < 14; i++) begin
      redirect_i = (i == 4);
      @(negedge clk);
      if (i == 4) begin
        checks++; if (id_valid_o !== 1'b0) begin failures++; $display("FAIL rr_noconsume valid=%0b exp=0", id_valid_o); end
        exp_pc = tgt;
      end else if (id_valid_o && id_ready_i) begin
        checks++;
        if (id_pc_o !== exp_pc || id_instr_o !== mem_word(exp_pc)) begin
          failures++; $display("FAIL rr_stream pc=%h exp=%h", id_pc_o, exp_pc);
        end
        exp_pc += 64'd4;
      end
      step();
    end
    redirect_i = 1'b0;
  endtask

`ifdef RV_IFU_MISALIGN_EN
  task automatic test_misalign();
    redirect_i = 1'b1; redirect_pc_i = 64'h102;
    step();
    redirect_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (misalign_o !== 1'b1 || imem_req_o !== 1'b0 || id_valid_o !== 1'b0) begin
        failures++; $display("FAIL mis_halt misalign=%0b req=%0b valid=%0b exp=1/0/0", misalign_o, imem_req_o, id_valid_o);
      end
      step();
    end
    redirect_i = 1'b1; redirect_pc_i = 64'h200;
    step();
    redirect_i = 1'b0;
    @(negedge clk);
    checks++; if (misalign_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 64'h200) begin
      failures++; $display("FAIL mis_clear misalign=%0b req=%0b addr=%h exp=0/1/200", misalign_o, imem_req_o, imem_addr_o);
    end
    step(); step();
    @(negedge clk);
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 64'h200) begin failures++; $display("FAIL mis_resume valid=%0b pc=%h exp=1/200", id_valid_o, id_pc_o); end
    exp_pc = 64'h204;
    step();
  endtask
`endif

  task automatic test_random();
    logic [63:0] tgt, p_addr;
    logic        p_req, p_gnt;
    int          acc, del;
    p_req = 1'b0; p_gnt = 1'b0; p_addr = '0; acc = 0; del = 0;
    for (int i = 0; i < 408; i++) begin
      if (i < 400) begin
        imem_gnt_i = ($urandom_range(0, 3) != 0);
        id_ready_i = ($urandom_range(0, 3) != 0);
        redirect_i = (i == 0) || ($urandom_range(0, 24) == 0);
      end else begin
        imem_gnt_i = 1'b0; id_ready_i = 1'b1; redirect_i = 1'b0;
      end
      tgt = {$urandom(), $urandom()};
      tgt[1:0] = 2'b00;
      redirect_pc_i = tgt;
      @(negedge clk);
      if (redirect_i) begin
        checks++; if (id_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin failures++; $display("FAIL rnd_redirect valid=%0b req=%0b exp=0/0", id_valid_o, imem_req_o); end
      end
      if (p_req && !p_gnt) begin
        checks++; if (imem_addr_o !== p_addr) begin failures++; $display("FAIL rnd_hold addr=%h exp=%h", imem_addr_o, p_addr); end
      end
      if (id_valid_o && id_ready_i) begin
        checks++;
        if (id_pc_o !== exp_pc || id_instr_o !== mem_word(exp_pc)) begin
          failures++; $display("FAIL rnd_stream pc=%h instr=%h exp=%h/%h", id_pc_o, id_instr_o, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 64'd4; del++;
      end
      if (imem_req_o && imem_gnt_i) acc++;
      if (redirect_i) begin exp_pc = tgt; acc = 0; del = 0; end
      p_req = imem_req_o; p_gnt = imem_gnt_i; p_addr = imem_addr_o;
      step();
    end
    checks++; if (acc != del) begin failures++; $display("FAIL rnd_lost accepted=%0d delivered=%0d", acc, del); end
  endtask

  task automatic test_reset_mid();
    imem_gnt_i = 1'b1; id_ready_i = 1'b1; redirect_i = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL mid_rst_req got=%0b exp=0", imem_req_o); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (imem_addr_o !== 64'h0 || id_valid_o !== 1'b0 || id_instr_o !== 32'h0 || id_pc_o !== 64'h0) begin
      failures++; $display("FAIL mid_rst_out addr=%h valid=%0b instr=%h pc=%h exp=all0", imem_addr_o, id_valid_o, id_instr_o, id_pc_o);
    end
`ifdef RV_IFU_MISALIGN_EN
    checks++; if (misalign_o !== 1'b0) begin failures++; $display("FAIL mid_rst_misalign got=%0b exp=0", misalign_o); end
`endif
    step(); step();
    @(negedge clk);
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 64'h0) begin failures++; $display("FAIL mid_rst_restart valid=%0b pc=%h exp=1/0", id_valid_o, id_pc_o); end
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_gnt_stall();
    test_redirect();
    test_redirect_ready();
`ifdef RV_IFU_MISALIGN_EN
    test_misalign();
`endif
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
